// File: rtl/mii_rx_assembler.sv
// MII receive nibble-to-byte assembler with preamble/SFD detection and one-byte holding buffer.
// Optional statistics counters are enabled with `define MII_RX_ASSEMBLER_STATS_EN.
module mii_rx_assembler #(
  parameter int MIN_PREAMBLE = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mii_rx_ce,
  input  logic        mii_rx_dv,
  input  logic        mii_rx_er,
  input  logic [3:0]  mii_rxd,
  output logic [7:0]  data,
  output logic        valid,
  output logic        last,
  output logic        err,
  output logic [15:0] frame_count,
  output logic [15:0] error_count
);

  typedef enum logic [2:0] {DROP, IDLE, PREAMBLE, DATA_LO, DATA_HI} state_t;

  localparam logic [3:0] MIN_P = 4'(MIN_PREAMBLE);

  state_t     state, state_d;
  logic [3:0] pre_cnt, pre_cnt_d;
  logic [3:0] lo_nib, lo_nib_d;
  logic [7:0] hold, hold_d;
  logic       hold_vld, hold_vld_d;
  logic       ferr, ferr_d;
  logic       emit, emit_last, emit_err;
  logic       err_evt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= DROP;
      pre_cnt  <= '0;
      lo_nib   <= '0;
      hold     <= '0;
      hold_vld <= 1'b0;
      ferr     <= 1'b0;
    end else begin
      state    <= state_d;
      pre_cnt  <= pre_cnt_d;
      lo_nib   <= lo_nib_d;
      hold     <= hold_d;
      hold_vld <= hold_vld_d;
      ferr     <= ferr_d;
    end
  end

  always_comb begin
    state_d    = state;
    pre_cnt_d  = pre_cnt;
    lo_nib_d   = lo_nib;
    hold_d     = hold;
    hold_vld_d = hold_vld;
    ferr_d     = ferr;
    emit       = 1'b0;
    emit_last  = 1'b0;
    emit_err   = 1'b0;
    err_evt    = 1'b0;
    if (mii_rx_ce) begin
      unique case (state)
        DROP: if (!mii_rx_dv) state_d = IDLE;
        IDLE: if (mii_rx_dv) begin
          if (mii_rxd == 4'h5 && !mii_rx_er) begin
            state_d   = PREAMBLE;
            pre_cnt_d = 4'd1;
          end else begin
            state_d = DROP;
            err_evt = 1'b1;
          end
        end
        PREAMBLE: begin
          if (!mii_rx_dv) begin
            state_d = IDLE;
            err_evt = 1'b1;
          end else if (!mii_rx_er && mii_rxd == 4'h5) begin
            if (pre_cnt != 4'hF) pre_cnt_d = pre_cnt + 4'd1;
          end else if (!mii_rx_er && mii_rxd == 4'hD && pre_cnt >= MIN_P) begin
            state_d = DATA_LO;
            ferr_d  = 1'b0;
          end else begin
            state_d = DROP;
            err_evt = 1'b1;
          end
        end
        DATA_LO, DATA_HI: begin
          if (!mii_rx_dv) begin
            state_d = IDLE;
            // An empty frame (SFD then end) has nothing to carry an err flag.
            if (hold_vld) begin
              emit       = 1'b1;
              emit_last  = 1'b1;
              emit_err   = ferr | (state == DATA_HI);
              hold_vld_d = 1'b0;
            end else begin
              err_evt = 1'b1;
            end
          end else begin
            if (mii_rx_er) ferr_d = 1'b1;
            if (state == DATA_LO) begin
              lo_nib_d = mii_rxd;
              state_d  = DATA_HI;
            end else begin
              hold_d     = {mii_rxd, lo_nib};
              hold_vld_d = 1'b1;
              emit       = hold_vld;
              state_d    = DATA_LO;
            end
          end
        end
        default: state_d = DROP;
      endcase
    end
  end

  // Output register: emits the byte currently in the holding buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
      err   <= 1'b0;
    end else begin
      valid <= emit;
      if (emit) begin
        data <= hold;
        last <= emit_last;
        err  <= emit_err;
      end
    end
  end

`ifdef MII_RX_ASSEMBLER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_count <= '0;
      error_count <= '0;
    end else begin
      if ((emit && emit_last && emit_err) || err_evt) begin
        if (error_count != 16'hFFFF) error_count <= error_count + 16'd1;
      end
      if (emit && emit_last && !emit_err) begin
        if (frame_count != 16'hFFFF) frame_count <= frame_count + 16'd1;
      end
    end
  end
`else
  logic stats_unused;
  assign stats_unused = err_evt;
  assign frame_count  = 16'h0000;
  assign error_count  = 16'h0000;
`endif

endmodule

// File: tb/tb_mii_rx_assembler.sv
// Scoreboard bench for mii_rx_assembler: expected bytes queued per frame, popped on each valid.
module tb_mii_rx_assembler;
  localparam int MIN_PRE = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce = 1'b0, dv = 1'b0, er = 1'b0;
  logic [3:0]  rxd = 4'h0;
  logic [7:0]  data;
  logic        valid, last, err;
  logic [15:0] frame_count, error_count;

  mii_rx_assembler #(.MIN_PREAMBLE(MIN_PRE)) dut (
    .clk(clk), .rst_n(rst_n), .mii_rx_ce(ce), .mii_rx_dv(dv), .mii_rx_er(er),
    .mii_rxd(rxd), .data(data), .valid(valid), .last(last), .err(err),
    .frame_count(frame_count), .error_count(error_count)
  );

  always #5 clk = ~clk;

  int          n_vec = 0, n_bad = 0;
  logic [9:0]  sb[$];          // {data, last, err}
  logic [3:0]  nbuf[256];
  int          exp_frm = 0, exp_err = 0;
  logic [9:0]  mon_e;
  logic        valid_q = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] cnt_frm();
`ifdef MII_RX_ASSEMBLER_STATS_EN
    return exp_frm;
`else
    return 0;
`endif
  endfunction

  function automatic logic [31:0] cnt_err();
`ifdef MII_RX_ASSEMBLER_STATS_EN
    return exp_err;
`else
    return 0;
`endif
  endfunction

  always @(negedge clk) begin
    if (rst_n && valid) begin
      if (valid_q) chk("double_pulse", 1, 0);
      if (sb.size() == 0) chk("spurious_valid", 1, 0);
      else begin
        mon_e = sb.pop_front();
        chk("data", {24'd0, data}, {24'd0, mon_e[9:2]});
        chk("last", {31'd0, last}, {31'd0, mon_e[1]});
        chk("err",  {31'd0, err},  {31'd0, mon_e[0]});
      end
    end
    valid_q = valid;
  end

  // One nibble per five clocks; ce high for one cycle.
  task automatic nib(input logic v, input logic e, input logic [3:0] d);
    repeat (4) @(negedge clk);
    dv = v; er = e; rxd = d; ce = 1'b1;
    @(negedge clk);
    ce = 1'b0;
  endtask

  function automatic int sat_inc(input int x);
    return (x == 65535) ? 65535 : x + 1;
  endfunction

  task automatic frame(input int npre, input logic [3:0] sfd, input int nn, input int er_at);
    int  nb;
    logic fe;
    if (npre < MIN_PRE || sfd != 4'hD) begin
      exp_err = sat_inc(exp_err);
    end else begin
      nb = nn / 2;
      fe = (er_at >= 0 && er_at < nn) || (nn % 2 == 1);
      if (nb == 0) exp_err = sat_inc(exp_err);
      else begin
        for (int i = 0; i < nb; i++)
          sb.push_back({nbuf[2*i+1], nbuf[2*i], (i == nb-1), (i == nb-1) ? fe : 1'b0});
        if (fe) exp_err = sat_inc(exp_err);
        else    exp_frm = sat_inc(exp_frm);
      end
    end
    repeat (npre) nib(1'b1, 1'b0, 4'h5);
    nib(1'b1, 1'b0, sfd);
    for (int i = 0; i < nn; i++) nib(1'b1, (i == er_at), nbuf[i]);
    nib(1'b0, 1'b0, 4'h0);
    nib(1'b0, 1'b0, 4'h0);
    chk("sb_drained", sb.size(), 0);
    chk("frame_count", {16'd0, frame_count}, cnt_frm());
    chk("error_count", {16'd0, error_count}, cnt_err());
  endtask

  task automatic fill_seq(input int n);
    for (int i = 0; i < n; i++) nbuf[i] = 4'(i + 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'd0, valid}, 0);
    chk("rst_data",  {24'd0, data}, 0);
    chk("rst_last",  {31'd0, last}, 0);
    chk("rst_err",   {31'd0, err}, 0);
    chk("rst_frm",   {16'd0, frame_count}, 0);
    chk("rst_errc",  {16'd0, error_count}, 0);
    rst_n = 1'b1;
    nib(1'b0, 1'b0, 4'h0);

    // Normal, receive error, odd nibble count.
    fill_seq(6);  frame(4, 4'hD, 6, -1);
    fill_seq(6);  frame(4, 4'hD, 6, 2);
    nbuf[0] = 4'hA; nbuf[1] = 4'hB; nbuf[2] = 4'hC;
    frame(2, 4'hD, 3, -1);
    // Short preamble, bad SFD nibble, empty frame, saturated preamble count.
    fill_seq(4);  frame(1, 4'hD, 2, -1);
    fill_seq(4);  frame(3, 4'h7, 2, -1);
    frame(3, 4'hD, 0, -1);
    fill_seq(4);  frame(20, 4'hD, 4, -1);

    for (int k = 0; k < 4; k++) begin
      int nn;
      nn = $urandom_range(2, 24);
      for (int i = 0; i < nn; i++) nbuf[i] = 4'($urandom_range(0, 15));
      frame(MIN_PRE + k, 4'hD, nn, (k == 2) ? 5 : -1);
    end

    // Reset in the data phase of a 64-byte frame.
    for (int i = 0; i < 128; i++) nbuf[i] = 4'($urandom_range(0, 15));
    for (int i = 0; i < 19; i++) sb.push_back({nbuf[2*i+1], nbuf[2*i], 1'b0, 1'b0});
    repeat (3) nib(1'b1, 1'b0, 4'h5);
    nib(1'b1, 1'b0, 4'hD);
    for (int i = 0; i < 40; i++) nib(1'b1, 1'b0, nbuf[i]);
    repeat (2) @(negedge clk);
    chk("pre_rst_sb", sb.size(), 0);
    rst_n = 1'b0;
    exp_frm = 0; exp_err = 0;
    repeat (2) @(negedge clk);
    chk("mid_rst_valid", {31'd0, valid}, 0);
    chk("mid_rst_data",  {24'd0, data}, 0);
    chk("mid_rst_frm",   {16'd0, frame_count}, 0);
    chk("mid_rst_errc",  {16'd0, error_count}, 0);
    rst_n = 1'b1;
    for (int i = 40; i < 128; i++) nib(1'b1, 1'b0, nbuf[i]);
    nib(1'b0, 1'b0, 4'h0);
    nib(1'b0, 1'b0, 4'h0);
    chk("post_rst_quiet", sb.size(), 0);
    chk("post_rst_errc", {16'd0, error_count}, 0);
    fill_seq(10); frame(5, 4'hD, 10, -1);

`ifdef MII_RX_ASSEMBLER_STATS_EN
    force dut.error_count = 16'hFFFF;
    @(negedge clk);
    release dut.error_count;
    exp_err = 65535;
    fill_seq(2); frame(1, 4'hD, 2, -1);
    fill_seq(4); frame(3, 4'hD, 3, -1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mii_rx_assembler.md
MII_RX_ASSEMBLER -- requirements
Module: mii_rx_assembler

Interface
REQ-001 SHALL have one clock, `clk`, and an asynchronous, active-low reset, `rst_n`.
REQ-002 Parameter `MIN_PREAMBLE`, default 2: minimum number of 0x5 preamble nibbles required before the SFD nibble is accepted.
REQ-003 Port `clk`  in  1: MII-side system clock (125 MHz).
REQ-004 Port `rst_n`  in  1: asynchronous active-low reset.
REQ-005 Port `mii_rx_ce`  in  1: one-cycle nibble strobe; the MII inputs SHALL be sampled only when it is high.
REQ-006 Port `mii_rx_dv`  in  1: MII receive data valid.
REQ-007 Port `mii_rx_er`  in  1: MII receive error.
REQ-008 Port `mii_rxd`  in  4: MII receive nibble; the low nibble of each byte arrives first.
REQ-009 Port `data`  out  8: assembled frame byte, excluding preamble and SFD.
REQ-010 Port `valid`  out  1: one-cycle pulse qualifying `data`, `last` and `err`.
REQ-011 Port `last`  out  1: marks the final byte of a frame.
REQ-012 Port `err`  out  1: valid only with `last`; the frame is bad.
REQ-013 Port `frame_count`  out  16: number of good frames delivered.
REQ-014 Port `error_count`  out  16: number of bad or aborted frames.

Function
REQ-015 States SHALL be DROP, IDLE, PREAMBLE, DATA_LO and DATA_HI; all transitions SHALL occur only on cycles where `mii_rx_ce` is high.
REQ-016 DROP SHALL go to IDLE on `!mii_rx_dv`; DROP SHALL otherwise hold and produce no output.
REQ-017 IDLE SHALL behave as follows.
- `dv && rxd==4'h5 && !er` -> PREAMBLE, with the preamble count set to 1.
- `dv` with any other nibble or with `er` -> DROP, and `error_count` increments.
REQ-018 PREAMBLE SHALL behave as follows.
- `rxd==5`: the count increments, saturating at 15.
- `rxd==D` with count >= `MIN_PREAMBLE`: -> DATA_LO, and the frame error flag clears.
- `rxd==D` with count < `MIN_PREAMBLE`, any other nibble, `er`, or `!dv`: -> DROP (or IDLE if `!dv`), and `error_count` increments.
REQ-019 In DATA_LO, on `dv` the nibble SHALL be stored as bits [3:0] and the state SHALL go to DATA_HI.
REQ-020 In DATA_HI, on `dv` the nibble SHALL complete bits [7:4] and the state SHALL go to DATA_LO.
REQ-021 While in DATA_LO or DATA_HI, `dv && er` SHALL set a sticky frame error flag.
REQ-022 Holding buffer: a completed byte SHALL be placed in a one-byte holding register.
- If the register already held a byte, the old byte SHALL be emitted with `valid`=1 and `last`=0 in the cycle after the sampling edge.
REQ-023 End of frame (`!dv` in DATA_LO or DATA_HI):
- If a byte is held, it SHALL be emitted with `last`=1 and `err` = frame error flag OR (state==DATA_HI, i.e. odd nibble count), and the state SHALL go to IDLE.
REQ-024 If no byte is held at end of frame (SFD immediately followed by `!dv`), nothing SHALL be emitted and `error_count` SHALL increment.
REQ-025 Frame completion SHALL increment `frame_count` if `err`=0 and `error_count` if `err`=1; both counters SHALL saturate at 16'hFFFF.
REQ-026 `valid` SHALL be high for exactly one `clk` cycle per byte, and there SHALL be at most one pulse per `mii_rx_ce` strobe.
REQ-027 Latency from the sampling edge of a frame's last nibble to the `valid`/`last` pulse SHALL be one `mii_rx_ce` interval plus one `clk` cycle.
REQ-028 `data`, `last` and `err` SHALL hold their values until the next `valid` pulse.
REQ-029 Output handshake: there SHALL be no backpressure; the downstream stage SHALL accept every pulse.

Reset
REQ-030 While `rst_n` is low, the state SHALL be DROP, `valid`, `last` and `err` SHALL be 0, `data` SHALL be 8'h00, the holding register SHALL be empty, and both counters SHALL be 0.
REQ-031 On reset release with `dv` high (mid-frame), the block SHALL stay in DROP until `!dv` is sampled, and SHALL emit no partial frame.

Configuration
REQ-032 The macro `MII_RX_ASSEMBLER_STATS_EN` SHALL control statistics.
- Defined: `frame_count` and `error_count` SHALL operate per REQ-025.
- Undefined: both ports SHALL remain present, SHALL be tied to 16'h0000, and no counter flops SHALL be inferred.

Verification
REQ-033 Normal frame: `ce` every 5th cycle, nibbles 5,5,5,5,D, then 1,2,3,4,5,6, then `dv`=0 -> bytes 0x21, 0x43, 0x65 with `valid` pulses, `last` only on 0x65, `err`=0, `frame_count`=1.
REQ-034 Receive error: same frame with `er`=1 on nibble 3 -> three bytes emitted, `last`+`err`=1 on 0x65, `error_count`=1, `frame_count`=0.
REQ-035 Odd nibble count: nibbles 5,5,D,A,B,C then `dv`=0 -> single byte 0xBA with `last`=1 and `err`=1.
REQ-036 Bad preamble: nibbles 5,D with `MIN_PREAMBLE`=2 -> no `valid`, DROP until `dv`=0, `error_count`=1.
REQ-037 Reset mid-frame: deassert `rst_n` during the data phase of a 64-byte frame -> no `valid` until the next frame; the next frame is received intact.
REQ-038 Saturation (macro defined): force `error_count` to 16'hFFFF, then send a bad frame -> the count stays at 16'hFFFF; with the macro undefined, both counts read 0 throughout.
